// File: rtl/soc_system_pio_out_if.sv
// Avalon-MM slave bus bundle for the output PIO: address, select, write strobe,
// write data and registered read data.
interface soc_system_pio_out_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_out.sv
// Avalon-MM output PIO with atomic set/clear and a retriggerable timed pulse.
// out_port is the OR of the data register and the currently pulsed bits.
module soc_system_pio_out #(
    parameter int unsigned       WIDTH        = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
    parameter logic [31:0]       PULSE_CYCLES = 32'd50000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    soc_system_pio_out_if.slave  bus,
    output logic [WIDTH-1:0]     out_port
);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_PULSE    = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] pulse_mask_reg;
    logic [WIDTH-1:0] pulse_mask_next;
    logic [31:0]      pulse_cnt_reg;
    logic [31:0]      pulse_cnt_next;
    logic [31:0]      readdata_reg;
    logic [31:0]      read_mux;

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic             pulse_wr;
    logic             pulse_expiring;

    assign wr_en          = bus.chipselect && !bus.write_n;
    assign wd             = bus.writedata[WIDTH-1:0];
    assign pulse_wr       = wr_en && (bus.address == ADDR_PULSE) && (wd != '0);
    assign pulse_expiring = (pulse_cnt_reg == 32'd1);

    // Upper write-data bits beyond WIDTH carry no meaning for this block.
    generate
        if (WIDTH < 32) begin : g_unused_wd
            logic unused_wd_bits;
            assign unused_wd_bits = ^bus.writedata[31:WIDTH];
        end
    endgenerate

    // Data register next value: plain write, atomic set or atomic clear.
    always_comb begin
        data_next = data_reg;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_next = wd;
                ADDR_OUTSET:   data_next = data_reg | wd;
                ADDR_OUTCLEAR: data_next = data_reg & ~wd;
                default:       data_next = data_reg;
            endcase
        end
    end

    // Pulse timer: a nonzero write (re)arms the shared counter; on the expiry
    // edge a new write replaces the mask rather than extending the old bits.
    always_comb begin
        pulse_mask_next = pulse_mask_reg;
        pulse_cnt_next  = pulse_cnt_reg;
        if (pulse_wr) begin
            pulse_mask_next = pulse_expiring ? wd : (pulse_mask_reg | wd);
            pulse_cnt_next  = PULSE_CYCLES;
        end else if (pulse_cnt_reg != 32'd0) begin
            pulse_cnt_next = pulse_cnt_reg - 32'd1;
            if (pulse_expiring) begin
                pulse_mask_next = '0;
            end
        end
    end

    // Read mux, zero-extended; write-only registers read back as zero.
    always_comb begin
        read_mux = '0;
        case (bus.address)
            ADDR_DATA:  read_mux[WIDTH-1:0] = data_reg;
            ADDR_PULSE: read_mux[WIDTH-1:0] = pulse_mask_reg;
            default:    read_mux = '0;
        endcase
    end

    // State and read-data registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg       <= RESET_VALUE;
            pulse_mask_reg <= '0;
            pulse_cnt_reg  <= '0;
            readdata_reg   <= '0;
        end else begin
            data_reg       <= data_next;
            pulse_mask_reg <= pulse_mask_next;
            pulse_cnt_reg  <= pulse_cnt_next;
            readdata_reg   <= read_mux;
        end
    end

    assign bus.readdata = readdata_reg;

    // Each output pin is its data bit or its pulse bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
            assign out_port[gi] = data_reg[gi] | pulse_mask_reg[gi];
        end
    endgenerate

endmodule
